// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the registered integer ALU.
//   alu_op_t           : 3-bit operation select carried on ALUOp
//   ALU_WIDTH_DEFAULT  : default operand/result width
// Build macro used by the ALU: ALU_EXT_OPS_EN (enables XOR / SLT opcodes).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SRL = 3'd4,
        OP_SRA = 3'd5,
        OP_XOR = 3'd6,
        OP_SLT = 3'd7
    } alu_op_t;

endpackage : alu_pkg

// File: rtl/alu_shifter.sv
// -----------------------------------------------------------------------------
// alu_shifter
// Combinational right barrel shifter, shared by logical and arithmetic shifts.
// Built as SHW stages; stage gi shifts by 2**gi when shamt[gi] is set.
// Ports:
//   data   [WIDTH-1:0] in  : value to shift
//   shamt  [SHW-1:0]   in  : shift amount
//   arith              in  : 1 = fill with data[WIDTH-1], 0 = zero fill
//   result [WIDTH-1:0] out : shifted value
// -----------------------------------------------------------------------------
module alu_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   shamt,
    input  logic             arith,
    output logic [WIDTH-1:0] result
);

    // The fill bit is taken from the original operand's MSB, so every stage
    // inserts the same bit regardless of what earlier stages did.
    logic             w_fill;
    logic [WIDTH-1:0] w_stage [0:SHW];

    assign w_fill     = arith & data[WIDTH-1];
    assign w_stage[0] = data;

    genvar gi;
    generate
        for (gi = 0; gi < SHW; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign w_stage[gi+1] = shamt[gi]
                ? {{SH{w_fill}}, w_stage[gi][WIDTH-1:SH]}
                : w_stage[gi];
        end
    endgenerate

    assign result = w_stage[SHW];

endmodule : alu_shifter

// File: rtl/alu_unit.sv
// -----------------------------------------------------------------------------
// alu_unit
// Registered integer ALU: result C and flag zero are captured on the clock
// edge where in_valid is high; out_valid marks the cycle after acceptance.
// When in_valid is low, C and zero hold and out_valid drops.
// Ports:
//   clk                  in  : rising-edge clock
//   rst_n                in  : synchronous active-low reset
//   in_valid             in  : A, B, ALUOp valid this cycle
//   A, B   [WIDTH-1:0]   in  : operands (B[SHW-1:0] is the shift amount)
//   ALUOp  [2:0]         in  : operation select (alu_pkg::alu_op_t)
//   out_valid            out : C holds the result of an accepted operation
//   C      [WIDTH-1:0]   out : registered result
//   zero                 out : registered (C == 0)
// Build macro: ALU_EXT_OPS_EN enables XOR (110) and SLT (111); without it
// those opcodes yield 0.
// -----------------------------------------------------------------------------
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUOp,
    output logic             out_valid,
    output logic [WIDTH-1:0] C,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    alu_op_t          w_op;
    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_result;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_c;
    logic             r_zero;

    assign w_op = alu_op_t'(ALUOp);

    // One shared adder: subtraction is A + ~B + 1. SLT reuses the difference.
    assign w_sub   = (w_op == OP_SUB) || (w_op == OP_SLT);
    assign w_b_eff = B ^ {WIDTH{w_sub}};
    assign w_sum   = A + w_b_eff + {{(WIDTH-1){1'b0}}, w_sub};

    alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .data   (A),
        .shamt  (B[SHW-1:0]),
        .arith  (w_op == OP_SRA),
        .result (w_shift)
    );

`ifdef ALU_EXT_OPS_EN
    // Signed less-than: if the signs differ, A is smaller exactly when it is
    // negative; otherwise the sign of A-B cannot overflow and decides.
    logic w_slt;
    assign w_slt = (A[WIDTH-1] != B[WIDTH-1]) ? A[WIDTH-1] : w_sum[WIDTH-1];
`endif

    always_comb begin
        w_result = '0;
        case (w_op)
            OP_ADD,
            OP_SUB:  w_result = w_sum;
            OP_AND:  w_result = A & B;
            OP_OR:   w_result = A | B;
            OP_SRL,
            OP_SRA:  w_result = w_shift;
`ifdef ALU_EXT_OPS_EN
            OP_XOR:  w_result = A ^ B;
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_slt};
`else
            OP_XOR,
            OP_SLT:  w_result = '0;
`endif
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_zero      <= 1'b1;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_c    <= w_result;
                r_zero <= (w_result == '0);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign C         = r_c;
    assign zero      = r_zero;

endmodule : alu_unit

// File: tb/tb_alu_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_unit
// Self-checking bench for alu_unit: directed cases followed by randomized
// operations compared against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUOp;
    logic        out_valid;
    logic [31:0] C;
    logic        zero;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_c;

    alu_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .ALUOp     (ALUOp),
        .out_valid (out_valid),
        .C         (C),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model written straight from the opcode table.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        int unsigned     sh;
        logic signed [31:0] sa;
        sh = b % 32;
        sa = a;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a >> sh;
            3'd5: return sa >>> sh;
`ifdef ALU_EXT_OPS_EN
            3'd6: return a ^ b;
            3'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`else
            3'd6: return 32'd0;
            3'd7: return 32'd0;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Present one operation, then check the registered result one edge later.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [31:0] expect_c);
        @(negedge clk);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        ALUOp    = op;
        @(posedge clk);
        #1;
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".C"}, C, expect_c);
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, (expect_c == 32'd0)});
        exp_c = expect_c;
        $display("op %s A=%h B=%h op=%0d C=%h", tag, a, b, op, C);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        logic        rv;

        // Reset held with a valid operation pending: reset must win.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        A        = 32'd5;
        B        = 32'd3;
        ALUOp    = 3'd0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst.C", C, 32'd0);
            check("rst.zero", {31'd0, zero}, 32'd1);
            check("rst.valid", {31'd0, out_valid}, 32'd0);
            $display("reset cycle %0d C=%h zero=%b valid=%b", i, C, zero, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first.C", C, 32'd8);
        check("first.valid", {31'd0, out_valid}, 32'd1);
        check("first.zero", {31'd0, zero}, 32'd0);
        $display("first op after reset C=%h", C);

        // Arithmetic wrap
        run_op("add_wrap", 32'hFFFF_FFFF, 32'd1, 3'd0, 32'h0000_0000);
        run_op("sub_wrap", 32'd0, 32'd1, 3'd1, 32'hFFFF_FFFF);
        // Logic
        run_op("and", 32'hF0F0_1234, 32'h0FF0_FF00, 3'd2, 32'h00F0_1200);
        run_op("or",  32'hF0F0_1234, 32'h0FF0_FF00, 3'd3, 32'hFFF0_FF34);
        // Shifts, including ignored upper B bits and the boundary amounts
        run_op("sra2",   32'h8000_0000, 32'd2, 3'd5, 32'hE000_0000);
        run_op("srl2",   32'h8000_0000, 32'd2, 3'd4, 32'h2000_0000);
        run_op("sra_hi", 32'h8000_0000, 32'h0000_0021, 3'd5, 32'hC000_0000);
        run_op("srl0",   32'h8765_4321, 32'd0, 3'd4, 32'h8765_4321);
        run_op("sra0",   32'h8765_4321, 32'd0, 3'd5, 32'h8765_4321);
        run_op("srl31",  32'h8000_0000, 32'd31, 3'd4, 32'h0000_0001);
        run_op("sra31",  32'h8000_0000, 32'd31, 3'd5, 32'hFFFF_FFFF);

        // Back-to-back throughput: four consecutive accepted operations
        run_op("b2b0", 32'd10, 32'd20, 3'd0, 32'd30);
        run_op("b2b1", 32'd50, 32'd8,  3'd1, 32'd42);
        run_op("b2b2", 32'hFF, 32'h0F, 3'd2, 32'h0F);
        run_op("b2b3", 32'h100, 32'h1, 3'd3, 32'h101);

        // Idle: result and flag hold, valid drops
        @(negedge clk);
        in_valid = 1'b0;
        A        = 32'hDEAD_BEEF;
        B        = 32'd0;
        ALUOp    = 3'd1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("idle.valid", {31'd0, out_valid}, 32'd0);
            check("idle.C", C, 32'h101);
            check("idle.zero", {31'd0, zero}, 32'd0);
            $display("idle cycle %0d C=%h valid=%b", i, C, out_valid);
        end

        // Extended opcodes
`ifdef ALU_EXT_OPS_EN
        run_op("xor",     32'd7, 32'hFFFF_FFFF, 3'd6, 32'hFFFF_FFF8);
        run_op("slt",     32'd7, 32'hFFFF_FFFF, 3'd7, 32'd0);
        run_op("slt_swp", 32'hFFFF_FFFF, 32'd7, 3'd7, 32'd1);
`else
        run_op("op6", 32'd7, 32'hFFFF_FFFF, 3'd6, 32'd0);
        run_op("op7", 32'd7, 32'hFFFF_FFFF, 3'd7, 32'd0);
        run_op("op7_swp", 32'hFFFF_FFFF, 32'd7, 3'd7, 32'd0);
`endif

        // Randomized operations with random idle cycles
        for (int i = 0; i < 300; i++) begin
            rv  = ($urandom_range(0, 3) != 0);
            ra  = $urandom;
            rb  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
            rop = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) rb = ra;  // exercise zero/equal cases
            @(negedge clk);
            in_valid = rv;
            A        = ra;
            B        = rb;
            ALUOp    = rop;
            if (rv) exp_c = model(ra, rb, rop);
            @(posedge clk);
            #1;
            check("rnd.valid", {31'd0, out_valid}, {31'd0, rv});
            check("rnd.C", C, exp_c);
            check("rnd.zero", {31'd0, zero}, {31'd0, (exp_c == 32'd0)});
            $display("rnd %0d v=%b A=%h B=%h op=%0d C=%h", i, rv, ra, rb, rop, C);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_unit
